// File: rtl/ring_buffer_reader_pkg.sv
// Shared types and constants for the ring_buffer read-side engine.
// Imported by the top level and the skid buffer.
package ring_buffer_reader_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_LEN_W = 8;

    // The skid holds two entries, so a 2-bit occupancy count is enough.
    localparam logic [1:0] SKID_EMPTY = 2'd0;
    localparam logic [1:0] SKID_ONE   = 2'd1;
    localparam logic [1:0] SKID_FULL  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ring_buffer_reader_skid.sv
// Two-entry registered FIFO between the ring_buffer pops and the output stream.
// The head entry drives the outputs directly, so the output data is registered.
module rb_skid_buffer
    import ring_buffer_reader_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [1:0]       count_q;
    logic             do_pop;

    assign do_pop = pop && (count_q != SKID_EMPTY);

    // The writer only pushes into a full skid when it pops in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= SKID_EMPTY;
        end else begin
            case (count_q)
                SKID_EMPTY: begin
                    if (push) begin
                        head_q  <= push_data;
                        count_q <= SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (push && do_pop) begin
                        head_q <= push_data;
                    end else if (push) begin
                        tail_q  <= push_data;
                        count_q <= SKID_FULL;
                    end else if (do_pop) begin
                        count_q <= SKID_EMPTY;
                    end
                end
                default: begin
                    if (do_pop) begin
                        head_q <= tail_q;
                        if (push) begin
                            tail_q <= push_data;
                        end else begin
                            count_q <= SKID_ONE;
                        end
                    end
                end
            endcase
        end
    end

    assign out_valid = (count_q != SKID_EMPTY);
    assign out_data  = head_q;
    assign count     = count_q;

endmodule

// File: rtl/ring_buffer_reader.sv
// Read-side engine for ring_buffer: drains len_i words per start command onto
// a valid/ready stream, tagging the final word with m_last_o.
module ring_buffer_reader
    import ring_buffer_reader_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned LEN_W = DEFAULT_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    input  logic             rb_empty_i,
    input  logic [WIDTH-1:0] rb_data_i,
    output logic             rb_dequeue_o,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [WIDTH-1:0] m_data_o,
    output logic             m_last_o
);

    state_t           state_q;
    state_t           state_d;
    logic [LEN_W-1:0] rem_q;
    logic [1:0]       skid_cnt;
    logic             handshake;
    logic             space;
    logic             pop_word;
    logic             rem_is_one;
    logic [WIDTH:0]   skid_in;
    logic [WIDTH:0]   skid_out;

    assign handshake  = m_valid_o & m_ready_i;
    assign space      = (skid_cnt < SKID_FULL) | handshake;
    assign rem_is_one = (rem_q == LEN_W'(1));

    // Gated by rst so nothing is taken from the ring_buffer during a reset edge.
    assign pop_word = (state_q == ST_RUN) & ~rb_empty_i & (rem_q != '0) & space & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) && start_i) begin
                rem_q <= len_i;
            end else if (pop_word) begin
                rem_q <= rem_q - 1'b1;
            end
        end
    end

    // RUN leaves on the edge that hands off the final word, so done_o rises
    // in the cycle right after that handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = (len_i != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if ((rem_q == '0) &&
                    ((skid_cnt == SKID_EMPTY) || ((skid_cnt == SKID_ONE) && handshake))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = (state_q == ST_DONE);
    assign rb_dequeue_o = pop_word;
    assign skid_in      = {rem_is_one, rb_data_i};

    rb_skid_buffer #(
        .WIDTH (WIDTH + 1)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (pop_word),
        .push_data (skid_in),
        .pop       (m_ready_i),
        .out_valid (m_valid_o),
        .out_data  (skid_out),
        .count     (skid_cnt)
    );

    assign m_data_o = skid_out[WIDTH-1:0];
    assign m_last_o = skid_out[WIDTH];

endmodule

// File: tb/tb_ring_buffer_reader.sv
// Bench for ring_buffer_reader: a queue-style ring_buffer model feeds the DUT and
// every output word is compared with the word expected from the buffer order.
module tb_ring_buffer_reader;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned LEN_W = 8;
    localparam int          MEM_N = 1024;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_i = 1'b0;
    logic [LEN_W-1:0] len_i = '0;
    logic             busy_o;
    logic             done_o;
    logic             rb_empty_i;
    logic [WIDTH-1:0] rb_data_i;
    logic             rb_dequeue_o;
    logic             m_valid_o;
    logic             m_ready_i = 1'b1;
    logic [WIDTH-1:0] m_data_o;
    logic             m_last_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // ring_buffer model: words live in mem[rd_idx .. wr_idx-1]
    logic [WIDTH-1:0] mem [0:MEM_N-1];
    int rd_idx = 0;
    int wr_idx = 0;
    logic [WIDTH-1:0] feed [$];

    // reference bookkeeping for the burst in flight
    int base = 0;
    int burst_len = 0;
    int accepted = 0;
    int popped = 0;
    int done_due = -10;
    bit hold = 1'b0;
    logic [WIDTH-1:0] hold_data = '0;
    logic hold_last = 1'b0;

    int ready_mode = 0;
    int pat = 0;

    always #5 clk = ~clk;

    ring_buffer_reader #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .len_i        (len_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .rb_empty_i   (rb_empty_i),
        .rb_data_i    (rb_data_i),
        .rb_dequeue_o (rb_dequeue_o),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i),
        .m_data_o     (m_data_o),
        .m_last_o     (m_last_o)
    );

    assign rb_empty_i = (rd_idx == wr_idx);
    assign rb_data_i  = mem[rd_idx % MEM_N];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rb_dequeue_o) rd_idx <= rd_idx + 1;
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: m_ready_i = 1'b1;
            1: m_ready_i = 1'($urandom_range(1));
            default: begin
                m_ready_i = (pat % 3 == 0);
                pat++;
            end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: judged mid-cycle, so what it sees is what the next edge commits.
    always @(negedge clk) begin
        if (rst) begin
            hold = 1'b0;
        end else begin
            chk("done_pulse", done_o, cyc == done_due);
            if (hold) begin
                chk("hold_data", m_data_o, hold_data);
                chk("hold_last", m_last_o, hold_last);
            end
            hold      = m_valid_o && !m_ready_i;
            hold_data = m_data_o;
            hold_last = m_last_o;
            if (rb_dequeue_o) begin
                chk("deq_nonempty", rb_empty_i, 1'b0);
                popped++;
            end
            if (m_valid_o && m_ready_i) begin
                chk("word_in_burst", accepted < burst_len, 1'b1);
                if (accepted < burst_len) begin
                    chk("data", m_data_o, mem[(base + accepted) % MEM_N]);
                    chk("last", m_last_o, (accepted + 1) == burst_len);
                    accepted++;
                    if (accepted == burst_len) done_due = cyc + 1;
                end
            end
            chk("skid_ahead", (popped - accepted) <= 2, 1'b1);
            chk("pop_bound", popped <= burst_len, 1'b1);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_word(input logic [WIDTH-1:0] v);
        mem[wr_idx % MEM_N] = v;
        wr_idx++;
    endtask

    task automatic start_burst(input int len);
        base      = rd_idx;
        burst_len = len;
        accepted  = 0;
        popped    = 0;
        if (len == 0) done_due = cyc + 1;
        start_i = 1'b1;
        len_i   = LEN_W'(len);
        step();
        start_i = 1'b0;
        chk("busy_after_start", busy_o, 1'b1);
    endtask

    task automatic wait_done(input int budget, output int done_cyc);
        done_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            if (done_o) begin
                done_cyc = cyc;
                break;
            end
            if (feed.size() > 0 && $urandom_range(2) == 0) push_word(feed.pop_front());
            step();
        end
        chk("done_timeout", done_cyc >= 0, 1'b1);
        chk("deq_count", popped, burst_len);
        chk("accept_count", accepted, burst_len);
        // a start presented in the DONE cycle must be ignored
        start_i = 1'b1;
        len_i   = LEN_W'(2);
        step();
        start_i = 1'b0;
        chk("start_in_done_ignored", busy_o, 1'b0);
    endtask

    initial begin
        int s;
        int dc;
        int rd_before;
        int len;
        int pre;
        logic [WIDTH-1:0] txt [0:4];

        txt[0] = "a"; txt[1] = "b"; txt[2] = "c"; txt[3] = "d"; txt[4] = "e";
        for (int i = 0; i < MEM_N; i++) mem[i] = '0;

        // reset held for two edges with a start request and a non-empty buffer
        for (int i = 0; i < 5; i++) push_word(txt[i]);
        rst = 1'b1; start_i = 1'b1; len_i = LEN_W'(5);
        for (int r = 0; r < 2; r++) begin
            @(posedge clk); #1;
            chk("rst_busy", busy_o, 1'b0);
            chk("rst_done", done_o, 1'b0);
            chk("rst_deq", rb_dequeue_o, 1'b0);
            chk("rst_valid", m_valid_o, 1'b0);
            chk("rst_last", m_last_o, 1'b0);
            chk("rst_data", m_data_o, '0);
        end
        start_i = 1'b0; len_i = '0; rst = 1'b0;
        step();
        chk("idle_after_rst", busy_o, 1'b0);
        chk("no_pop_in_rst", rd_idx, 0);

        // basic burst, ready held high: one word per cycle
        ready_mode = 0;
        s = cyc;
        start_burst(5);
        wait_done(50, dc);
        chk("basic_latency", dc - s, 7);
        chk("basic_drained", rb_empty_i, 1'b1);

        // backpressure: ready 1,0,0,1,...
        for (int i = 0; i < 4; i++) push_word(txt[i]);
        ready_mode = 2; pat = 0;
        start_burst(4);
        wait_done(100, dc);
        ready_mode = 0;

        // underrun: 6 requested, 3 buffered, 3 more arrive 10 cycles later
        for (int i = 0; i < 3; i++) push_word(txt[i]);
        start_burst(6);
        step(10);
        chk("underrun_busy", busy_o, 1'b1);
        chk("underrun_no_deq", rb_dequeue_o, 1'b0);
        chk("underrun_accepted", accepted, 3);
        push_word("x"); push_word("y"); push_word("z");
        wait_done(50, dc);

        // zero-length start
        rd_before = rd_idx;
        start_burst(0);
        chk("zero_done", done_o, 1'b1);
        chk("zero_valid", m_valid_o, 1'b0);
        chk("zero_deq", rb_dequeue_o, 1'b0);
        step();
        chk("zero_idle", busy_o, 1'b0);
        chk("zero_no_pop", rd_idx, rd_before);

        // start pulses during a 3-word burst are ignored
        push_word("p"); push_word("q"); push_word("r");
        for (int i = 0; i < 4; i++) push_word(8'($urandom));
        ready_mode = 1;
        start_burst(3);
        for (int i = 0; i < 2; i++) begin
            start_i = 1'b1; len_i = LEN_W'(7);
            step();
            start_i = 1'b0;
            step();
        end
        wait_done(100, dc);
        ready_mode = 0;

        // reset after two of five words accepted; the next burst reads the head
        for (int i = 0; i < 5; i++) push_word(txt[i]);
        start_burst(5);
        for (int i = 0; i < 20; i++) begin
            if (accepted >= 2) break;
            step();
        end
        chk("two_accepted", accepted, 2);
        rst = 1'b1;
        step();
        chk("midrst_valid", m_valid_o, 1'b0);
        chk("midrst_busy", busy_o, 1'b0);
        chk("midrst_done", done_o, 1'b0);
        burst_len = 0; accepted = 0; popped = 0;
        rst = 1'b0;
        step();
        start_burst(2);
        wait_done(50, dc);

        // randomized bursts with random ready and late-arriving data
        ready_mode = 1;
        repeat (6) begin
            len = $urandom_range(12, 1);
            pre = $urandom_range(len, 0);
            for (int i = 0; i < len; i++) begin
                if (i < pre) push_word(8'($urandom));
                else feed.push_back(8'($urandom));
            end
            start_burst(len);
            wait_done(600, dc);
            feed.delete();
        end
        ready_mode = 0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
